// File: rtl/arbitro_ula_logica_8bits_pkg.sv
// Shared definitions for the two-requester logic-unit arbiter.
// Contents: default widths, logic-unit opcode encodings and the FSM
// state encoding used by arbitro_ula_logica_8bits.
package arbitro_ula_logica_8bits_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int NREQ_DEF  = 2;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;

   typedef enum logic [1:0] {
      OCIOSO   = 2'b00,
      EXECUTA  = 2'b01,
      RESPONDE = 2'b10
   } estado_t;

endpackage

// File: rtl/arbitro_ula_logica_8bits_ula.sv
// unidade_logica_8bits: purely combinational bitwise logic unit.
// Ports: op_i - opcode (AND/OR/XOR/NOT A); a_i, b_i - operands;
//        y_o  - result, same width as the operands.
// The XOR path reuses the 8-bit XOR block, one instance per byte lane,
// so WIDTH must be a multiple of 8.
module unidade_logica_8bits
   import arbitro_ula_logica_8bits_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] y_o
);

   logic [WIDTH-1:0] xor_y;

   generate
      for (genvar gi = 0; gi < WIDTH / 8; gi++) begin : g_xor_lane
         xor_8bits u_xor (
            .a_i (a_i[gi*8 +: 8]),
            .b_i (b_i[gi*8 +: 8]),
            .y_o (xor_y[gi*8 +: 8])
         );
      end
   endgenerate

   always_comb begin
      y_o = '0;
      case (op_i)
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_XOR:  y_o = xor_y;
         default: y_o = ~a_i;   // OP_NOT: operand B is ignored
      endcase
   end

endmodule

// File: rtl/xor_8bits.sv
// 8-bit bitwise XOR operation block.
// Ports: a_i, b_i - 8-bit operands; y_o - a_i ^ b_i.
module xor_8bits (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] y_o
);

   assign y_o = a_i ^ b_i;

endmodule

// File: rtl/arbitro_ula_logica_8bits.sv
// Round-robin arbiter/sequencer sharing one logic unit between two clients.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   req[1:0]            - request levels, held until gnt is seen
//   op0/a0/b0, op1/a1/b1- opcode and operands of requester 0 / 1
//   gnt[1:0]            - one-cycle one-hot grant; operands captured then
//   ocupado             - high whenever a transaction is in progress
//   res_valid[1:0]      - one-hot result valid for the owning requester
//   ack[1:0]            - per-requester result acknowledge
//   resultado, zero     - registered result and its zero flag
// Sequence: OCIOSO (arbitrate, latch) -> EXECUTA (register result)
//           -> RESPONDE (hold until ack from owner) -> OCIOSO.
module arbitro_ula_logica_8bits
   import arbitro_ula_logica_8bits_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NREQ  = NREQ_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   input  logic [1:0]       op0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [1:0]       op1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic [NREQ-1:0]  gnt,
   output logic             ocupado,
   output logic [NREQ-1:0]  res_valid,
   input  logic [NREQ-1:0]  ack,
   output logic [WIDTH-1:0] resultado,
   output logic             zero
);

   localparam logic [NREQ-1:0] UM = NREQ'(1);

   estado_t          estado_q;
   logic             ptr_q;
   logic             dono_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [NREQ-1:0]  gnt_q;
   logic [NREQ-1:0]  res_valid_q;
   logic [WIDTH-1:0] res_q;
   logic             zero_q;

   logic             vencedor_d;
   logic [WIDTH-1:0] ula_y;

   // Contention goes to the pointer; otherwise the lone requester wins.
   always_comb begin
      vencedor_d = 1'b0;
      if (req[0] && req[1]) begin
         vencedor_d = ptr_q;
      end else begin
         vencedor_d = req[1];
      end
   end

   unidade_logica_8bits #(
      .WIDTH (WIDTH)
   ) u_ula (
      .op_i (op_q),
      .a_i  (a_q),
      .b_i  (b_q),
      .y_o  (ula_y)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado_q    <= OCIOSO;
         ptr_q       <= 1'b0;
         dono_q      <= 1'b0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         gnt_q       <= '0;
         res_valid_q <= '0;
         res_q       <= '0;
         zero_q      <= 1'b0;
      end else begin
         gnt_q <= '0;
         case (estado_q)
            OCIOSO: begin
               if (|req) begin
                  dono_q   <= vencedor_d;
                  op_q     <= vencedor_d ? op1 : op0;
                  a_q      <= vencedor_d ? a1  : a0;
                  b_q      <= vencedor_d ? b1  : b0;
                  gnt_q    <= UM << vencedor_d;
                  estado_q <= EXECUTA;
               end
            end
            EXECUTA: begin
               res_q       <= ula_y;
               zero_q      <= (ula_y == '0);
               res_valid_q <= UM << dono_q;
               estado_q    <= RESPONDE;
            end
            RESPONDE: begin
               // Only the owner's ack closes the transaction.
               if (ack[dono_q]) begin
                  res_valid_q <= '0;
                  ptr_q       <= ~dono_q;
                  estado_q    <= OCIOSO;
               end
            end
            default: begin
               estado_q <= OCIOSO;
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign res_valid = res_valid_q;
   assign resultado = res_q;
   assign zero      = zero_q;
   assign ocupado   = (estado_q != OCIOSO);

endmodule

// File: tb/tb_arbitro_ula_logica_8bits.sv
// Self-checking bench for arbitro_ula_logica_8bits using a result scoreboard.
module tb_arbitro_ula_logica_8bits;

   logic       clk;
   logic       rst_n;
   logic [1:0] req;
   logic [1:0] op0, op1;
   logic [7:0] a0, b0, a1, b1;
   logic [1:0] gnt;
   logic       ocupado;
   logic [1:0] res_valid;
   logic [1:0] ack;
   logic [7:0] resultado;
   logic       zero;

   typedef struct {
      int         dono;
      logic [7:0] res;
      logic       zero;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   arbitro_ula_logica_8bits dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .op0       (op0),
      .a0        (a0),
      .b0        (b0),
      .op1       (op1),
      .a1        (a1),
      .b1        (b1),
      .gnt       (gnt),
      .ocupado   (ocupado),
      .res_valid (res_valid),
      .ack       (ack),
      .resultado (resultado),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] modelo(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~a;
      endcase
   endfunction

   task automatic push(input int dono, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      e.dono = dono;
      e.res  = modelo(op, a, b);
      e.zero = (e.res == 8'h00);
      sb.push_back(e);
   endtask

   // gnt and res_valid together are at most one-hot in every cycle.
   always @(negedge clk) begin
      if (rst_n && (gnt != 2'b00 || res_valid != 2'b00)) begin
         chk("onehot_excl", 32'($onehot0({gnt, res_valid})), 32'd1);
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_rv", 32'(res_valid), 0);
      chk("rst_res", 32'(resultado), 0);
      chk("rst_zero", 32'(zero), 0);
      chk("rst_ocupado", 32'(ocupado), 0);
   endtask

   // One transaction for the scoreboard head. Called right after req is
   // driven on a falling edge, so the grant is expected one edge later.
   task automatic txn(input bit drop_req, input bit mutate, input int wrong_ack, input int hold);
      exp_t e;
      int   cyc;
      logic [1:0] um;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
         return;
      end
      e   = sb[0];
      um  = 2'b01 << e.dono;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (gnt == 2'b00 && cyc < 20);
      chk("gnt_lat", 32'(cyc), 32'd1);
      chk("gnt", 32'(gnt), 32'(um));
      chk("ocupado_gnt", 32'(ocupado), 32'd1);
      if (drop_req) req = 2'b00;
      if (mutate) begin
         if (e.dono == 1) begin a1 = 8'h00; b1 = 8'h00; op1 = 2'b11; end
         else             begin a0 = 8'h00; b0 = 8'h00; op0 = 2'b11; end
      end
      @(negedge clk);
      chk("rv", 32'(res_valid), 32'(um));
      e = sb.pop_front();
      chk("resultado", 32'(resultado), 32'(e.res));
      chk("zero", 32'(zero), 32'(e.zero));
      $display("txn dono=%0d resultado=%02h zero=%0d", e.dono, resultado, zero);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("rv_hold", 32'(res_valid), 32'(um));
         chk("res_hold", 32'(resultado), 32'(e.res));
      end
      for (int i = 0; i < wrong_ack; i++) begin
         ack = ~um;
         @(negedge clk);
         chk("rv_wrong_ack", 32'(res_valid), 32'(um));
         chk("ocupado_wrong_ack", 32'(ocupado), 32'd1);
      end
      ack = um;
      @(negedge clk);
      ack = 2'b00;
      chk("rv_after_ack", 32'(res_valid), 32'd0);
      chk("ocupado_after_ack", 32'(ocupado), 32'd0);
   endtask

   initial begin
      int cyc;
      rst_n = 1'b0; req = 2'b00; ack = 2'b00;
      op0 = 2'b00; a0 = 8'h00; b0 = 8'h00;
      op1 = 2'b00; a1 = 8'h00; b1 = 8'h00;
      @(negedge clk);
      do_reset();

      // Single XOR from requester 0, result held for a few cycles.
      req = 2'b01; op0 = 2'b10; a0 = 8'hA5; b0 = 8'h0F;
      push(0, op0, a0, b0);
      txn(1'b1, 1'b0, 0, 2);

      // NOT with all-ones operand gives zero.
      req = 2'b01; op0 = 2'b11; a0 = 8'hFF; b0 = 8'h5A;
      push(0, op0, a0, b0);
      txn(1'b1, 1'b0, 0, 0);

      // OR of zeros gives zero; non-owner ack ignored for 3 cycles.
      req = 2'b01; op0 = 2'b01; a0 = 8'h00; b0 = 8'h00;
      push(0, op0, a0, b0);
      txn(1'b1, 1'b0, 3, 0);

      // Operands changed after grant must not affect the result.
      req = 2'b10; op1 = 2'b00; a1 = 8'hF0; b1 = 8'h3C;
      push(1, op1, a1, b1);
      txn(1'b1, 1'b1, 0, 0);

      // Back to pointer 0, then strict alternation under constant contention.
      do_reset();
      op0 = 2'b01; a0 = 8'h12; b0 = 8'h40;
      op1 = 2'b11; a1 = 8'h3C; b1 = 8'hFF;
      req = 2'b11;
      for (int i = 0; i < 4; i++) push(i % 2, (i % 2) ? op1 : op0, (i % 2) ? a1 : a0, (i % 2) ? b1 : b0);
      for (int i = 0; i < 4; i++) txn(1'b0, 1'b0, 0, 0);
      req = 2'b00;

      // Reset while a result is being presented aborts it silently.
      @(negedge clk);
      req = 2'b01; op0 = 2'b01; a0 = 8'h81; b0 = 8'h00;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (gnt == 2'b00 && cyc < 20);
      chk("abort_gnt", 32'(gnt), 32'd1);
      req = 2'b00;
      @(negedge clk);
      chk("abort_rv_before", 32'(res_valid), 32'd1);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_late_rv", 32'(res_valid), 32'd0);
      end
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
